// File: rtl/sysid_info_regs.sv
// -----------------------------------------------------------------------------
// sysid_info_regs
//
// System-identification register block, Avalon-MM slave. Software reads it to
// identify the hardware build (ID, timestamp, capabilities) and to check bus
// and reset health (scratch register, 64-bit uptime counter, sticky status).
//
// Register map (word address):
//   0 ID         RO  SYSTEM_ID
//   1 TIMESTAMP  RO  TIMESTAMP
//   2 CAPS       RO  {VERSION, 8'd8, 8'(ADDR_WIDTH)}
//   3 UPTIME_LO  RO  uptime[31:0]; the same read latches uptime[63:32]
//   4 UPTIME_HI  RO  latched high word (atomic LO-then-HI pair)
//   5 SCRATCH    RW  byte-lane writable
//   6 STATUS     W1C bit0 WRAP, bit1 RST_SEEN; set beats clear
//   7, >=8       reserved, read 0, writes ignored
//
// Ports:
//   clock          in   system clock, rising edge
//   reset          in   synchronous active-high reset, beats any access
//   address        in   word address [ADDR_WIDTH-1:0]
//   read           in   read strobe, one cycle per transfer
//   write          in   write strobe, one cycle per transfer
//   writedata      in   write data [31:0]
//   byteenable     in   write byte lanes [3:0]
//   readdata       out  registered read data [31:0]
//   readdatavalid  out  one-cycle pulse the cycle after an accepted read
//
// Handshake: there is no waitrequest, so every read/write strobe seen on a
// non-reset clock edge is accepted on that edge. An accepted read produces
// readdatavalid=1 together with its data exactly one cycle later; readdata
// holds its value when no read was accepted. A read and a write in the same
// cycle both take effect, and the read returns the pre-write value.
// -----------------------------------------------------------------------------
module sysid_info_regs #(
    parameter logic [31:0] SYSTEM_ID     = 32'h00000000,
    parameter logic [31:0] TIMESTAMP     = 32'd1362613388,
    parameter logic [15:0] VERSION       = 16'h0002,
    parameter int unsigned ADDR_WIDTH    = 3,
    parameter logic [31:0] SCRATCH_RESET = 32'h00000000,
    parameter logic [63:0] UPTIME_RESET  = 64'h0
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic                  read,
    input  logic                  write,
    input  logic [31:0]           writedata,
    input  logic [3:0]            byteenable,
    output logic [31:0]           readdata,
    output logic                  readdatavalid
);

    localparam logic [2:0] W_ID      = 3'd0;
    localparam logic [2:0] W_TSTAMP  = 3'd1;
    localparam logic [2:0] W_CAPS    = 3'd2;
    localparam logic [2:0] W_UP_LO   = 3'd3;
    localparam logic [2:0] W_UP_HI   = 3'd4;
    localparam logic [2:0] W_SCRATCH = 3'd5;
    localparam logic [2:0] W_STATUS  = 3'd6;

    localparam logic [31:0] CAPS_WORD = {VERSION, 8'd8, 8'(ADDR_WIDTH)};

    logic [63:0] uptime_q,    uptime_d;
    logic [31:0] hi_shadow_q, hi_shadow_d;
    logic [31:0] scratch_q,   scratch_d;
    logic [1:0]  status_q,    status_d;
    logic [31:0] readdata_q,  readdata_d;
    logic        rdv_q;
    // High while reset is applied; the first non-reset edge uses it to raise
    // RST_SEEN.
    logic        in_reset_q;

    logic [31:0] addr_ext;
    logic        in_map;
    logic [2:0]  word;
    logic [31:0] rd_word;
    logic        wr_scratch;
    logic        wr_status;
    logic        wrap_evt;

    // Only addresses 0..7 decode to registers; anything above is reserved.
    assign addr_ext = 32'(address);
    assign in_map   = (addr_ext < 32'd8);
    assign word     = addr_ext[2:0];

    always_comb begin
        rd_word = 32'h0;
        if (in_map) begin
            case (word)
                W_ID:      rd_word = SYSTEM_ID;
                W_TSTAMP:  rd_word = TIMESTAMP;
                W_CAPS:    rd_word = CAPS_WORD;
                W_UP_LO:   rd_word = uptime_q[31:0];
                W_UP_HI:   rd_word = hi_shadow_q;
                W_SCRATCH: rd_word = scratch_q;
                W_STATUS:  rd_word = {30'h0, status_q};
                default:   rd_word = 32'h0;
            endcase
        end
    end

    always_comb begin
        wr_scratch = write && in_map && (word == W_SCRATCH);
        wr_status  = write && in_map && (word == W_STATUS) && byteenable[0];
        // Counter is about to roll over from all-ones to zero on this edge.
        wrap_evt   = &uptime_q;

        uptime_d   = uptime_q + 64'd1;

        // Latch the high half only when the low half is read, so a later HI
        // read pairs with that LO sample.
        hi_shadow_d = hi_shadow_q;
        if (read && in_map && (word == W_UP_LO)) begin
            hi_shadow_d = uptime_q[63:32];
        end

        scratch_d = scratch_q;
        if (wr_scratch) begin
            for (int i = 0; i < 4; i++) begin
                if (byteenable[i]) begin
                    scratch_d[i*8 +: 8] = writedata[i*8 +: 8];
                end
            end
        end

        // Clear first, then apply set events so a coincident set wins.
        status_d = status_q;
        if (wr_status) begin
            status_d = status_q & ~writedata[1:0];
        end
        if (wrap_evt) begin
            status_d[0] = 1'b1;
        end
        if (in_reset_q) begin
            status_d[1] = 1'b1;
        end

        readdata_d = readdata_q;
        if (read) begin
            readdata_d = rd_word;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            uptime_q    <= UPTIME_RESET;
            hi_shadow_q <= 32'h0;
            scratch_q   <= SCRATCH_RESET;
            status_q    <= 2'b00;
            readdata_q  <= 32'h0;
            rdv_q       <= 1'b0;
            in_reset_q  <= 1'b1;
        end else begin
            uptime_q    <= uptime_d;
            hi_shadow_q <= hi_shadow_d;
            scratch_q   <= scratch_d;
            status_q    <= status_d;
            readdata_q  <= readdata_d;
            rdv_q       <= read;
            in_reset_q  <= 1'b0;
        end
    end

    assign readdata      = readdata_q;
    assign readdatavalid = rdv_q;

endmodule

// File: tb/tb_sysid_info_regs.sv
module tb_sysid_info_regs;

  logic        clock = 1'b0;
  logic        reset;
  logic        read;
  logic        write;
  logic [7:0]  address;
  logic [31:0] writedata;
  logic [3:0]  byteenable;

  logic [31:0] a_rdata, b_rdata, c_rdata, d_rdata;
  logic        a_rdv,   b_rdv,   c_rdv,   d_rdv;

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- clock ----------------
  always #5 clock = ~clock;

  // ---------------- DUTs ----------------
  // a: main map checks, nonzero scratch reset
  sysid_info_regs #(
    .SYSTEM_ID(32'hCAFE0001), .ADDR_WIDTH(3), .SCRATCH_RESET(32'hDEADBEEF)
  ) u_a (
    .clock(clock), .reset(reset), .address(address[2:0]), .read(read),
    .write(write), .writedata(writedata), .byteenable(byteenable),
    .readdata(a_rdata), .readdatavalid(a_rdv)
  );

  // b: wider address for reserved-address checks
  sysid_info_regs #(
    .SYSTEM_ID(32'hCAFE0001), .ADDR_WIDTH(4)
  ) u_b (
    .clock(clock), .reset(reset), .address(address[3:0]), .read(read),
    .write(write), .writedata(writedata), .byteenable(byteenable),
    .readdata(b_rdata), .readdatavalid(b_rdv)
  );

  // c: uptime snapshot across the 32-bit carry
  sysid_info_regs #(
    .UPTIME_RESET(64'h0000_0001_FFFF_FFFE)
  ) u_c (
    .clock(clock), .reset(reset), .address(address[2:0]), .read(read),
    .write(write), .writedata(writedata), .byteenable(byteenable),
    .readdata(c_rdata), .readdatavalid(c_rdv)
  );

  // d: uptime close to 64-bit wrap
  sysid_info_regs #(
    .UPTIME_RESET(64'hFFFF_FFFF_FFFF_FFFD)
  ) u_d (
    .clock(clock), .reset(reset), .address(address[2:0]), .read(read),
    .write(write), .writedata(writedata), .byteenable(byteenable),
    .readdata(d_rdata), .readdatavalid(d_rdv)
  );

  // ---------------- vector table ----------------
  typedef struct {
    string       name;
    logic        rd;
    logic        wr;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        exp_rdv;
    logic        chk_data;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input string name, input logic rd, input logic wr,
                              input logic [7:0] addr, input logic [31:0] wdata,
                              input logic [3:0] be, input logic chk_data,
                              input logic [31:0] exp_data);
    vec_t v;
    v.name     = name;
    v.rd       = rd;
    v.wr       = wr;
    v.addr     = addr;
    v.wdata    = wdata;
    v.be       = be;
    v.exp_rdv  = rd;
    v.chk_data = chk_data;
    v.exp_data = exp_data;
    return v;
  endfunction

  // ---------------- driver tasks ----------------
  // Inputs change 1 time unit after the rising edge; outputs are sampled there
  // too, so each call covers exactly one clock edge.
  task automatic cyc(input logic rd, input logic wr, input logic [7:0] addr,
                     input logic [31:0] wd, input logic [3:0] be);
    read       = rd;
    write      = wr;
    address    = addr;
    writedata  = wd;
    byteenable = be;
    @(posedge clock);
    #1;
    read  = 1'b0;
    write = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 8'd0, 32'h0, 4'h0);
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- test ----------------
  initial begin
    reset      = 1'b1;
    read       = 1'b0;
    write      = 1'b0;
    address    = 8'd0;
    writedata  = 32'h0;
    byteenable = 4'h0;

    // Vector table for instance a.
    vecs.push_back(mk("rd_id",        1, 0, 8'd0, 32'h0,          4'h0, 1, 32'hCAFE0001));
    vecs.push_back(mk("rd_tstamp",    1, 0, 8'd1, 32'h0,          4'h0, 1, 32'd1362613388));
    vecs.push_back(mk("rd_caps",      1, 0, 8'd2, 32'h0,          4'h0, 1, 32'h00020803));
    vecs.push_back(mk("idle_hold",    0, 0, 8'd0, 32'h0,          4'h0, 1, 32'h00020803));
    vecs.push_back(mk("rd_scr_rst",   1, 0, 8'd5, 32'h0,          4'h0, 1, 32'hDEADBEEF));
    vecs.push_back(mk("wr_scr_full",  0, 1, 8'd5, 32'h11223344,   4'hF, 1, 32'hDEADBEEF));
    vecs.push_back(mk("wr_scr_lanes", 0, 1, 8'd5, 32'hAABBCCDD,   4'h5, 0, 32'h0));
    vecs.push_back(mk("rd_scr_merge", 1, 0, 8'd5, 32'h0,          4'h0, 1, 32'h11BB33DD));
    vecs.push_back(mk("rdwr_scr_old", 1, 1, 8'd5, 32'h01020304,   4'hF, 1, 32'h11BB33DD));
    vecs.push_back(mk("rd_scr_new",   1, 0, 8'd5, 32'h0,          4'h0, 1, 32'h01020304));
    vecs.push_back(mk("wr_ro_id",     0, 1, 8'd0, 32'hFFFFFFFF,   4'hF, 0, 32'h0));
    vecs.push_back(mk("wr_ro_ts",     0, 1, 8'd1, 32'hFFFFFFFF,   4'hF, 0, 32'h0));
    vecs.push_back(mk("wr_ro_caps",   0, 1, 8'd2, 32'hFFFFFFFF,   4'hF, 0, 32'h0));
    vecs.push_back(mk("wr_rsvd7",     0, 1, 8'd7, 32'hFFFFFFFF,   4'hF, 0, 32'h0));
    vecs.push_back(mk("rd_id_kept",   1, 0, 8'd0, 32'h0,          4'h0, 1, 32'hCAFE0001));
    vecs.push_back(mk("rd_ts_kept",   1, 0, 8'd1, 32'h0,          4'h0, 1, 32'd1362613388));
    vecs.push_back(mk("rd_caps_kept", 1, 0, 8'd2, 32'h0,          4'h0, 1, 32'h00020803));
    vecs.push_back(mk("rd_rsvd7",     1, 0, 8'd7, 32'h0,          4'h0, 1, 32'h0));
    vecs.push_back(mk("rd_status",    1, 0, 8'd6, 32'h0,          4'h0, 1, 32'h00000002));
    vecs.push_back(mk("w1c_no_be0",   0, 1, 8'd6, 32'h00000002,   4'h2, 0, 32'h0));
    vecs.push_back(mk("rd_status_2",  1, 0, 8'd6, 32'h0,          4'h0, 1, 32'h00000002));
    vecs.push_back(mk("w1c_rst_seen", 0, 1, 8'd6, 32'h00000002,   4'h1, 0, 32'h0));
    vecs.push_back(mk("rd_status_0",  1, 0, 8'd6, 32'h0,          4'h0, 1, 32'h00000000));
    vecs.push_back(mk("idle_end",     0, 0, 8'd0, 32'h0,          4'h0, 1, 32'h00000000));

    // Read during the reset cycle is dropped.
    read    = 1'b1;
    address = 8'd0;
    @(posedge clock);
    #1;
    read  = 1'b0;
    reset = 1'b0;
    check("reset_rdv",   {31'h0, a_rdv}, 32'h0);
    check("reset_rdata", a_rdata,        32'h0);

    // Table: each row is one clock edge, outputs checked right after it.
    foreach (vecs[i]) begin
      cyc(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].be);
      check({vecs[i].name, "_rdv"}, {31'h0, a_rdv}, {31'h0, vecs[i].exp_rdv});
      if (vecs[i].chk_data) check({vecs[i].name, "_data"}, a_rdata, vecs[i].exp_data);
    end

    // Reserved space on the 4-bit-address instance.
    cyc(1'b0, 1'b1, 8'd9, 32'hFFFFFFFF, 4'hF);
    cyc(1'b0, 1'b1, 8'd7, 32'hFFFFFFFF, 4'hF);
    cyc(1'b1, 1'b0, 8'd9, 32'h0, 4'h0);
    check("b_rd9_rdv",  {31'h0, b_rdv}, 32'h1);
    check("b_rd9_data", b_rdata, 32'h0);
    cyc(1'b1, 1'b0, 8'd7, 32'h0, 4'h0);
    check("b_rd7_data", b_rdata, 32'h0);
    cyc(1'b1, 1'b0, 8'd2, 32'h0, 4'h0);
    check("b_caps", b_rdata, 32'h00020804);
    idle(1);
    check("b_idle_rdv", {31'h0, b_rdv}, 32'h0);

    // Atomic LO/HI snapshot across the 32-bit carry.
    pulse_reset();
    idle(1);
    cyc(1'b1, 1'b0, 8'd3, 32'h0, 4'h0);
    check("c_lo", c_rdata, 32'hFFFFFFFF);
    idle(4);
    cyc(1'b1, 1'b0, 8'd4, 32'h0, 4'h0);
    check("c_hi_shadow", c_rdata, 32'h00000001);

    // 64-bit wrap and sticky WRAP bit.
    pulse_reset();
    idle(3);
    cyc(1'b1, 1'b0, 8'd6, 32'h0, 4'h0);
    check("d_status_wrap", d_rdata, 32'h00000003);
    cyc(1'b0, 1'b1, 8'd6, 32'h00000001, 4'hF);
    cyc(1'b1, 1'b0, 8'd6, 32'h0, 4'h0);
    check("d_status_w1c", d_rdata, 32'h00000002);
    cyc(1'b1, 1'b0, 8'd3, 32'h0, 4'h0);
    check("d_lo_after_wrap", d_rdata, 32'h00000003);
    cyc(1'b1, 1'b0, 8'd4, 32'h0, 4'h0);
    check("d_hi_after_wrap", d_rdata, 32'h00000000);

    // W1C on the exact wrap edge: set wins.
    pulse_reset();
    idle(2);
    cyc(1'b0, 1'b1, 8'd6, 32'h00000001, 4'h1);
    cyc(1'b1, 1'b0, 8'd6, 32'h0, 4'h0);
    check("d_set_beats_clr", d_rdata, 32'h00000003);

    // Read together with reset: dropped, readdata cleared, uptime restarts.
    reset = 1'b1;
    cyc(1'b1, 1'b0, 8'd3, 32'h0, 4'h0);
    reset = 1'b0;
    check("mid_rst_c_rdv",   {31'h0, c_rdv}, 32'h0);
    check("mid_rst_c_rdata", c_rdata, 32'h0);
    check("mid_rst_a_rdata", a_rdata, 32'h0);
    cyc(1'b1, 1'b0, 8'd3, 32'h0, 4'h0);
    check("mid_rst_c_lo", c_rdata, 32'hFFFFFFFE);
    cyc(1'b1, 1'b0, 8'd5, 32'h0, 4'h0);
    check("mid_rst_a_scr", a_rdata, 32'hDEADBEEF);

    // One-cycle reset clears a written scratch and re-arms RST_SEEN.
    cyc(1'b0, 1'b1, 8'd5, 32'h5A5A5A5A, 4'hF);
    cyc(1'b1, 1'b0, 8'd5, 32'h0, 4'h0);
    check("a_scr_5a", a_rdata, 32'h5A5A5A5A);
    pulse_reset();
    cyc(1'b1, 1'b0, 8'd5, 32'h0, 4'h0);
    check("a_scr_after_rst", a_rdata, 32'hDEADBEEF);
    cyc(1'b1, 1'b0, 8'd6, 32'h0, 4'h0);
    check("a_status_after_rst", a_rdata, 32'h00000002);
    idle(1);
    check("final_rdv", {31'h0, a_rdv}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sysid_info_regs.md
Name: sysid_info_regs

Overview:
Parametrised system-identification register block, an Avalon-MM slave on the Nios II system interconnect. It extends the fixed two-word ID/timestamp slave to the following:
- a multi-word register map with registered reads and `readdatavalid`;
- a capability word;
- a 64-bit free-running uptime counter with an atomic high-word snapshot;
- a writable scratch register;
- a sticky status register.

Software uses it to identify the hardware build and to check bus and reset health.

Parameters:
SYSTEM_ID, 32'h00000000, value returned at word 0
TIMESTAMP, 32'd1362613388, build timestamp returned at word 1
VERSION, 16'h0002, block version reported in CAPS[31:16]
ADDR_WIDTH, 3, word-address width; legal range 3..8
SCRATCH_RESET, 32'h00000000, reset value of SCRATCH
UPTIME_RESET, 64'h0, reset value of the uptime counter (the bench uses it to reach wrap)

Ports:
clock  input  1  system clock; all logic on the rising edge
reset  input  1  synchronous, active-high reset
address  input  ADDR_WIDTH  word address
read  input  1  read strobe, single cycle per transfer
write  input  1  write strobe, single cycle per transfer
writedata  input  32  write data
byteenable  input  4  byte lanes for the write
readdata  output  32  registered read data
readdatavalid  output  1  high for exactly one cycle, the cycle after an accepted read

Behaviour:
- Reset (synchronous, reset=1 at the clock edge):
  - readdata=0, readdatavalid=0, SCRATCH=SCRATCH_RESET, uptime=UPTIME_RESET, hi_shadow=0, STATUS=0.
  - Reset has priority over any read or write in the same cycle.
  - A read issued in the reset cycle is dropped; no readdatavalid follows.
- Handshake:
  - No waitrequest; every read or write is accepted in the cycle it is asserted.
  - Read latency is exactly 1 cycle. readdata updates only on an accepted read and holds its value otherwise.
  - Back-to-back reads give back-to-back readdatavalid pulses.
- Read and write in the same cycle:
  - Both are performed.
  - readdata returns the pre-write register value.
- Register map (word address):
  - 0 ID, RO: SYSTEM_ID.
  - 1 TIMESTAMP, RO: TIMESTAMP.
  - 2 CAPS, RO: {VERSION[15:0], 8'd8 (implemented words), 8'(ADDR_WIDTH)}.
  - 3 UPTIME_LO, RO: returns uptime[31:0] as sampled in the read cycle. In the same edge, hi_shadow <= uptime[63:32].
  - 4 UPTIME_HI, RO: returns hi_shadow. It does not resample, so a LO then HI read pair is atomic.
  - 5 SCRATCH, RW: each byte lane i is written only when byteenable[i]=1.
  - 6 STATUS:
    - bit0 WRAP: sticky; set when uptime wraps 64'hFFFF_FFFF_FFFF_FFFF -> 0.
    - bit1 RST_SEEN: set on the first clock after reset deasserts. It flags that a reset has occurred.
    - Each bit is cleared by writing 1 (W1C, byteenable[0] required). Writing 0 has no effect.
    - If a set event and a W1C land in the same cycle, the set wins.
    - Bits 31:2 read 0.
  - 7, and any address >= 8 when ADDR_WIDTH > 3: reserved. Reads return 0; writes are ignored.
  - Writes to RO words are ignored; no side effects.
- Uptime counter:
  - 64-bit; increments by 1 every cycle that reset=0.
  - Wraps modulo 2^64.
  - Not affected by bus accesses.
- readdatavalid is never asserted without a preceding accepted read.

Test Plan:
- Reset, then read words 0, 1, 2 on consecutive cycles with SYSTEM_ID=32'hCAFE0001, ADDR_WIDTH=3 -> readdatavalid on 3 consecutive cycles; data 32'hCAFE0001, 32'd1362613388, 32'h00020803.
- Write SCRATCH 32'h11223344 with byteenable=4'b1111, then 32'hAABBCCDD with byteenable=4'b0101 -> SCRATCH reads 32'h11BB33DD. Read and write SCRATCH in the same cycle -> read returns 32'h11BB33DD, and the next read returns the new value.
- UPTIME_RESET=64'h0000_0001_FFFF_FFFE. Read LO exactly 1 cycle after reset release, then read HI 5 cycles later -> LO=32'hFFFFFFFF, HI=32'h00000001 (shadow, not the live 32'h00000002).
- UPTIME_RESET=64'hFFFF_FFFF_FFFF_FFFD:
  - Wait for wrap, then read STATUS -> 32'h3.
  - Write 32'h1 -> reads 32'h2.
  - Re-reset to the same init and issue W1C of bit0 on the exact wrap cycle -> bit0 remains 1.
- Write 32'hFFFFFFFF to words 0, 1, 2, 7 and read them back; with ADDR_WIDTH=4, read address 9 -> original values unchanged; address 7 and 9 return 0; each read gives one readdatavalid pulse.
- Mid-operation reset:
  - Assert read and reset together -> no readdatavalid next cycle; readdata=0; SCRATCH=SCRATCH_RESET; uptime restarts at UPTIME_RESET.
  - Then assert reset for 1 cycle while SCRATCH=32'h5A5A5A5A -> SCRATCH returns to reset value; STATUS=32'h2 after release.
